// File: rtl/banked_physical_memory.sv
// Multi-bank main-memory endpoint: strobe/ready handshake, fixed wait states, abort on strobe drop.
// Optional per-byte write enables when BANKED_PHYS_MEM_BYTE_WE_EN is defined.
module banked_physical_memory #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned WORD_AW     = 7,
    parameter int unsigned NBANKS      = 4,
    parameter int unsigned BANK_LSB    = 13,
    parameter int unsigned WAIT_CYCLES = 5
) (
    input  logic                clk,
    input  logic                clrn,
    input  logic [31:0]         a,
    input  logic [DATA_W-1:0]   din,
`ifdef BANKED_PHYS_MEM_BYTE_WE_EN
    input  logic [DATA_W/8-1:0] be,
`endif
    input  logic                strobe,
    input  logic                rw,
    output logic [DATA_W-1:0]   dout,
    output logic                ready
);

    localparam int unsigned NBYTES = DATA_W / 8;
    localparam int unsigned OFF_W  = $clog2(NBYTES);
    localparam int unsigned BANK_W = (NBANKS > 1) ? $clog2(NBANKS) : 1;
    localparam int unsigned CNT_W  = $clog2(WAIT_CYCLES + 1);
    localparam int unsigned DEPTH  = 2 ** WORD_AW;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [WORD_AW-1:0]   word_q;
    logic [BANK_W-1:0]    bank_q;
    logic [DATA_W-1:0]    din_q;
    logic                 rw_q;
    logic [NBYTES-1:0]    be_q;
    logic [NBYTES-1:0]    be_d;
    logic [BANK_W-1:0]    bank_d;
    logic                 do_access;
    logic                 unused_addr_bits;

    logic [DATA_W-1:0] mem [NBANKS][DEPTH];

    // Bits outside the word and bank fields only alias.
    assign unused_addr_bits = ^a;

    generate
        if (NBANKS > 1) begin : g_bank_sel
            assign bank_d = a[BANK_LSB +: BANK_W];
        end else begin : g_single_bank
            assign bank_d = '0;
        end
    endgenerate

`ifdef BANKED_PHYS_MEM_BYTE_WE_EN
    assign be_d = be;
`else
    assign be_d = '1;
`endif

    assign do_access = (state == BUSY) && strobe && (cnt == LAST_CNT);

    // Handshake FSM, latched request and registered outputs.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state  <= IDLE;
            cnt    <= '0;
            word_q <= '0;
            bank_q <= '0;
            din_q  <= '0;
            rw_q   <= 1'b0;
            be_q   <= '0;
            ready  <= 1'b0;
            dout   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (strobe) begin
                        word_q <= a[OFF_W +: WORD_AW];
                        bank_q <= bank_d;
                        din_q  <= din;
                        rw_q   <= rw;
                        be_q   <= be_d;
                        cnt    <= '0;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    if (!strobe) begin
                        state <= IDLE;
                    end else if (cnt == LAST_CNT) begin
                        ready <= 1'b1;
                        dout  <= rw_q ? '0 : mem[bank_q][word_q];
                        state <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    ready <= 1'b0;
                    dout  <= '0;
                    if (!strobe) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Storage is not reset; a write lands only on the completing edge.
    always_ff @(posedge clk) begin
        if (do_access && rw_q) begin
            for (int i = 0; i < int'(NBYTES); i++) begin
                if (be_q[i]) begin
                    mem[bank_q][word_q][i*8 +: 8] <= din_q[i*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_banked_physical_memory.sv
// Directed self-checking bench: default-config memory plus a WAIT_CYCLES=1, single-bank instance.
module tb_banked_physical_memory;

    logic        clk = 1'b0;
    logic        clrn;
    logic [31:0] a;
    logic [31:0] din;
    logic        rw;
    logic        strobe_m;
    logic        strobe_s;
    logic [31:0] dout_m;
    logic [31:0] dout_s;
    logic        ready_m;
    logic        ready_s;
`ifdef BANKED_PHYS_MEM_BYTE_WE_EN
    logic [3:0]  be;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    banked_physical_memory dut_m (
        .clk    (clk),
        .clrn   (clrn),
        .a      (a),
        .din    (din),
`ifdef BANKED_PHYS_MEM_BYTE_WE_EN
        .be     (be),
`endif
        .strobe (strobe_m),
        .rw     (rw),
        .dout   (dout_m),
        .ready  (ready_m)
    );

    banked_physical_memory #(.NBANKS(1), .WAIT_CYCLES(1)) dut_s (
        .clk    (clk),
        .clrn   (clrn),
        .a      (a),
        .din    (din),
`ifdef BANKED_PHYS_MEM_BYTE_WE_EN
        .be     (be),
`endif
        .strobe (strobe_s),
        .rw     (rw),
        .dout   (dout_s),
        .ready  (ready_s)
    );

    // One full access on the selected instance; lat = edges after E0 until ready (-1 on timeout).
    task automatic access(input bit s, input logic w, input logic [31:0] addr,
                          input logic [31:0] wd, output logic [31:0] rd, output int lat);
        @(negedge clk);
        a = addr; din = wd; rw = w;
        if (s) strobe_s = 1'b1; else strobe_m = 1'b1;
        lat = -1;
        rd  = 32'hx;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if ((s ? ready_s : ready_m) === 1'b1) begin
                lat = k;
                rd  = s ? dout_s : dout_m;
                break;
            end
        end
        @(negedge clk);
        strobe_m = 1'b0; strobe_s = 1'b0; rw = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        clrn = 1'b0; strobe_m = 1'b0; strobe_s = 1'b0; rw = 1'b0; a = '0; din = '0;
`ifdef BANKED_PHYS_MEM_BYTE_WE_EN
        be = 4'hF;
`endif
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (ready_m !== 1'b0) begin n_err++; $display("FAIL reset_ready got=%b exp=0", ready_m); end
        n_cmp++; if (dout_m !== 32'h0) begin n_err++; $display("FAIL reset_dout got=%h exp=0", dout_m); end
        @(negedge clk); clrn = 1'b1;
    endtask

    task automatic test_write_read();
        logic [31:0] rd; int lat;
        access(0, 1'b1, 32'h2000_2004, 32'hDEAD_BEEF, rd, lat);
        n_cmp++; if (lat !== 5) begin n_err++; $display("FAIL wr_latency got=%0d exp=5", lat); end
        n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL wr_dout_zero got=%h exp=0", rd); end
        access(0, 1'b0, 32'h2000_2004, 32'h0, rd, lat);
        n_cmp++; if (lat !== 5) begin n_err++; $display("FAIL rd_latency got=%0d exp=5", lat); end
        n_cmp++; if (rd !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL rd_data got=%h exp=deadbeef", rd); end
        n_cmp++; if (dout_m !== 32'h0) begin n_err++; $display("FAIL rd_dout_after got=%h exp=0", dout_m); end
        n_cmp++; if (ready_m !== 1'b0) begin n_err++; $display("FAIL rd_ready_after got=%b exp=0", ready_m); end
    endtask

    task automatic test_bank_alias();
        logic [31:0] rd; int lat;
        access(0, 1'b1, 32'h0000_0008, 32'h1111_1111, rd, lat);
        access(0, 1'b1, 32'h0000_2008, 32'h2222_2222, rd, lat);
        access(0, 1'b0, 32'h0000_0008, 32'h0, rd, lat);
        n_cmp++; if (rd !== 32'h1111_1111) begin n_err++; $display("FAIL bank0_iso got=%h exp=11111111", rd); end
        access(0, 1'b0, 32'h0000_0208, 32'h0, rd, lat);
        n_cmp++; if (rd !== 32'h1111_1111) begin n_err++; $display("FAIL word_alias got=%h exp=11111111", rd); end
        access(0, 1'b0, 32'h0000_2008, 32'h0, rd, lat);
        n_cmp++; if (rd !== 32'h2222_2222) begin n_err++; $display("FAIL bank1_data got=%h exp=22222222", rd); end
    endtask

    task automatic test_held_strobe();
        logic [31:0] rd; int lat; int pulses;
        pulses = 0;
        @(negedge clk);
        a = 32'h40; din = 32'h1234_5678; rw = 1'b1; strobe_m = 1'b1;
        @(posedge clk);
        @(negedge clk); din = 32'h0;
        repeat (15) begin
            @(posedge clk); #1;
            if (ready_m === 1'b1) pulses++;
        end
        @(negedge clk); strobe_m = 1'b0; rw = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (pulses !== 1) begin n_err++; $display("FAIL held_pulses got=%0d exp=1", pulses); end
        access(0, 1'b0, 32'h40, 32'h0, rd, lat);
        n_cmp++; if (rd !== 32'h1234_5678) begin n_err++; $display("FAIL held_data got=%h exp=12345678", rd); end
    endtask

    task automatic test_abort();
        logic [31:0] rd; int lat; int pulses;
        pulses = 0;
        access(0, 1'b1, 32'h80, 32'h5555_5555, rd, lat);
        @(negedge clk);
        a = 32'h80; din = 32'hAAAA_AAAA; rw = 1'b1; strobe_m = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk); strobe_m = 1'b0; rw = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (ready_m === 1'b1) pulses++;
        end
        n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL abort_pulses got=%0d exp=0", pulses); end
        access(0, 1'b0, 32'h80, 32'h0, rd, lat);
        n_cmp++; if (rd !== 32'h5555_5555) begin n_err++; $display("FAIL abort_data got=%h exp=55555555", rd); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; int lat; bit got;
        // Reset during a write's BUSY phase.
        @(negedge clk);
        a = 32'h80; din = 32'hCCCC_CCCC; rw = 1'b1; strobe_m = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); clrn = 1'b0; #1;
        n_cmp++; if (ready_m !== 1'b0) begin n_err++; $display("FAIL rst_busy_ready got=%b exp=0", ready_m); end
        n_cmp++; if (dout_m !== 32'h0) begin n_err++; $display("FAIL rst_busy_dout got=%h exp=0", dout_m); end
        @(negedge clk); clrn = 1'b1; strobe_m = 1'b0; rw = 1'b0;
        // Reset while a read's ready pulse is visible.
        @(negedge clk);
        a = 32'h80; rw = 1'b0; strobe_m = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (ready_m === 1'b1) begin got = 1'b1; break; end
        end
        n_cmp++; if (got !== 1'b1 || dout_m !== 32'h5555_5555) begin
            n_err++; $display("FAIL rst_pre_read got=%b/%h exp=1/55555555", got, dout_m);
        end
        #1 clrn = 1'b0; #1;
        n_cmp++; if (ready_m !== 1'b0) begin n_err++; $display("FAIL rst_done_ready got=%b exp=0", ready_m); end
        n_cmp++; if (dout_m !== 32'h0) begin n_err++; $display("FAIL rst_done_dout got=%h exp=0", dout_m); end
        @(negedge clk); clrn = 1'b1; strobe_m = 1'b0;
        access(0, 1'b0, 32'h80, 32'h0, rd, lat);
        n_cmp++; if (lat !== 5) begin n_err++; $display("FAIL rst_next_lat got=%0d exp=5", lat); end
        n_cmp++; if (rd !== 32'h5555_5555) begin n_err++; $display("FAIL rst_next_data got=%h exp=55555555", rd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; int lat;
        access(1, 1'b1, 32'h0, 32'hA0A0_A0A0, rd, lat);
        n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL small_wr_lat got=%0d exp=1", lat); end
        access(1, 1'b1, 32'h4, 32'hB1B1_B1B1, rd, lat);
        access(1, 1'b1, 32'h8, 32'hC2C2_C2C2, rd, lat);
        access(1, 1'b0, 32'h0, 32'h0, rd, lat);
        n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL small_rd_lat got=%0d exp=1", lat); end
        n_cmp++; if (rd !== 32'hA0A0_A0A0) begin n_err++; $display("FAIL small_rd0 got=%h exp=a0a0a0a0", rd); end
        access(1, 1'b0, 32'h8, 32'h0, rd, lat);
        n_cmp++; if (rd !== 32'hC2C2_C2C2) begin n_err++; $display("FAIL small_rd2 got=%h exp=c2c2c2c2", rd); end
        // Single bank: the bank field aliases onto word 1.
        access(1, 1'b1, 32'h2004, 32'hD3D3_D3D3, rd, lat);
        access(1, 1'b0, 32'h4, 32'h0, rd, lat);
        n_cmp++; if (rd !== 32'hD3D3_D3D3) begin n_err++; $display("FAIL small_alias got=%h exp=d3d3d3d3", rd); end
    endtask

`ifdef BANKED_PHYS_MEM_BYTE_WE_EN
    task automatic test_byte_en();
        logic [31:0] rd; int lat;
        be = 4'hF;
        access(0, 1'b1, 32'h100, 32'hFFFF_FFFF, rd, lat);
        be = 4'b0101;
        access(0, 1'b1, 32'h100, 32'h0000_0000, rd, lat);
        be = 4'h0;
        access(0, 1'b0, 32'h100, 32'h0, rd, lat);
        n_cmp++; if (rd !== 32'hFF00_FF00) begin n_err++; $display("FAIL be_merge got=%h exp=ff00ff00", rd); end
        access(0, 1'b1, 32'h100, 32'h1234_5678, rd, lat);
        n_cmp++; if (lat !== 5) begin n_err++; $display("FAIL be_zero_lat got=%0d exp=5", lat); end
        access(0, 1'b0, 32'h100, 32'h0, rd, lat);
        n_cmp++; if (rd !== 32'hFF00_FF00) begin n_err++; $display("FAIL be_zero_data got=%h exp=ff00ff00", rd); end
        be = 4'hF;
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_bank_alias();
        test_held_strobe();
        test_abort();
        test_reset_mid();
        test_back_to_back();
`ifdef BANKED_PHYS_MEM_BYTE_WE_EN
        test_byte_en();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
